// File: rtl/se_req_arbiter_if.sv
// Search-engine side bus of the request arbiter: lookup key out, ack/nak/result back.
// master = arbiter, slave = MAC search engine.
interface se_req_arbiter_if;
  logic [47:0] se_mac;
  logic [9:0]  se_hash;
  logic        se_source;
  logic [15:0] source_portmap;
  logic        se_req;
  logic        se_ack;
  logic        se_nak;
  logic [15:0] se_result;

  modport master (
    output se_mac,
    output se_hash,
    output se_source,
    output source_portmap,
    output se_req,
    input  se_ack,
    input  se_nak,
    input  se_result
  );

  modport slave (
    input  se_mac,
    input  se_hash,
    input  se_source,
    input  source_portmap,
    input  se_req,
    output se_ack,
    output se_nak,
    output se_result
  );
endinterface

// File: rtl/se_req_arbiter.sv
// Shares one MAC search engine between 4 frame processors: per-requester 2-deep
// request queues, round-robin grant, one outstanding search with a timeout guard.
module se_req_arbiter #(
  parameter int TIMEOUT = 64,
  parameter int QDEPTH  = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   req_i,
  input  logic [191:0] req_mac_i,
  input  logic [39:0]  req_hash_i,
  input  logic [3:0]   req_source_i,
  input  logic [63:0]  req_portmap_i,
  output logic [3:0]   req_ack_o,
  output logic [3:0]   req_nak_o,
  output logic [63:0]  req_result_o,
  output logic [3:0]   req_ovf_o,
  output logic         timeout_o,
  se_req_arbiter_if.master se
);

  localparam int CW = $clog2(TIMEOUT) + 1;

  typedef struct packed {
    logic        source;
    logic [15:0] portmap;
    logic [9:0]  hash;
    logic [47:0] mac;
  } entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;

  entry_t        q_mem [4][2];
  logic [3:0]    wr_ptr;
  logic [3:0]    rd_ptr;
  logic [1:0]    q_count [4];
  logic [3:0]    q_nonempty;
  logic [3:0]    push_ok;
  logic [3:0]    pop;

  logic [1:0]    last_grant;
  logic [1:0]    cur_g;
  logic [1:0]    grant_idx;
  logic [1:0]    cand;
  logic          grant_vld;
  entry_t        head;
  entry_t        se_q;

  logic          do_load;
  logic          do_ack;
  logic          do_nak;
  logic          do_tmo;
  logic [CW-1:0] tmo_cnt;

  always_comb begin
    for (int n = 0; n < 4; n++) begin
      q_nonempty[n] = (q_count[n] != 2'd0);
    end
  end

  always_comb begin
    for (int n = 0; n < 4; n++) begin
      pop[n] = (do_ack || do_nak) && (cur_g == 2'(n));
    end
  end

  // A full queue still accepts a push when its head retires on the same edge.
  always_comb begin
    for (int n = 0; n < 4; n++) begin
      push_ok[n] = req_i[n] && ((q_count[n] != 2'(QDEPTH)) || pop[n]);
    end
  end

  // Round-robin scan starting just after the last requester that was served.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = last_grant;
    cand      = last_grant;
    for (int i = 1; i <= 4; i++) begin
      cand = last_grant + 2'(i);
      if (!grant_vld && q_nonempty[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  assign head = q_mem[grant_idx][rd_ptr[grant_idx]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      req_ovf_o <= '0;
      for (int n = 0; n < 4; n++) begin
        q_count[n] <= 2'd0;
      end
    end else begin
      for (int n = 0; n < 4; n++) begin
        if (push_ok[n]) begin
          wr_ptr[n] <= ~wr_ptr[n];
        end
        if (pop[n]) begin
          rd_ptr[n] <= ~rd_ptr[n];
        end
        if (req_i[n] && !push_ok[n]) begin
          req_ovf_o[n] <= 1'b1;
        end
        case ({push_ok[n], pop[n]})
          2'b10:   q_count[n] <= q_count[n] + 2'd1;
          2'b01:   q_count[n] <= q_count[n] - 2'd1;
          default: q_count[n] <= q_count[n];
        endcase
      end
    end
  end

  // Queue storage needs no reset; occupancy is tracked by the pointers and counts.
  always_ff @(posedge clk) begin
    for (int n = 0; n < 4; n++) begin
      if (push_ok[n]) begin
        q_mem[n][wr_ptr[n]] <= {req_source_i[n], req_portmap_i[16*n +: 16],
                                req_hash_i[10*n +: 10], req_mac_i[48*n +: 48]};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    do_load   = 1'b0;
    do_ack    = 1'b0;
    do_nak    = 1'b0;
    do_tmo    = 1'b0;
    case (state)
      IDLE: begin
        if (grant_vld) begin
          do_load   = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        state_nxt = WAIT;
      end
      WAIT: begin
        if (se.se_ack) begin
          do_ack    = 1'b1;
          state_nxt = IDLE;
        end else if (se.se_nak) begin
          do_nak    = 1'b1;
          state_nxt = IDLE;
        end else if (tmo_cnt == CW'(TIMEOUT - 1)) begin
          do_nak    = 1'b1;
          do_tmo    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      se_q         <= '0;
      cur_g        <= 2'd0;
      last_grant   <= 2'd3;
      tmo_cnt      <= '0;
      req_ack_o    <= '0;
      req_nak_o    <= '0;
      req_result_o <= '0;
      timeout_o    <= 1'b0;
    end else begin
      req_ack_o <= '0;
      req_nak_o <= '0;
      timeout_o <= do_tmo;
      if (do_load) begin
        se_q  <= head;
        cur_g <= grant_idx;
      end
      if (state == ISSUE) begin
        tmo_cnt <= '0;
      end else if (state == WAIT) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
      if (do_ack) begin
        req_ack_o[cur_g]                     <= 1'b1;
        req_result_o[{cur_g, 4'b0000} +: 16] <= se.se_result;
      end
      if (do_nak) begin
        req_nak_o[cur_g] <= 1'b1;
      end
      if (do_ack || do_nak) begin
        last_grant <= cur_g;
      end
    end
  end

  assign se.se_mac         = se_q.mac;
  assign se.se_hash        = se_q.hash;
  assign se.se_source      = se_q.source;
  assign se.source_portmap = se_q.portmap;
  assign se.se_req         = (state == ISSUE);

endmodule

// File: tb/tb_se_req_arbiter.sv
// Directed bench for se_req_arbiter: latency, round-robin order, routing,
// overflow, nak/timeout/collision and asynchronous reset mid-search.
module tb_se_req_arbiter;
  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_i;
  logic [191:0] req_mac_i;
  logic [39:0]  req_hash_i;
  logic [3:0]   req_source_i;
  logic [63:0]  req_portmap_i;
  logic [3:0]   req_ack_o;
  logic [3:0]   req_nak_o;
  logic [63:0]  req_result_o;
  logic [3:0]   req_ovf_o;
  logic         timeout_o;

  se_req_arbiter_if sif ();

  se_req_arbiter #(.TIMEOUT(64), .QDEPTH(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_i         (req_i),
    .req_mac_i     (req_mac_i),
    .req_hash_i    (req_hash_i),
    .req_source_i  (req_source_i),
    .req_portmap_i (req_portmap_i),
    .req_ack_o     (req_ack_o),
    .req_nak_o     (req_nak_o),
    .req_result_o  (req_result_o),
    .req_ovf_o     (req_ovf_o),
    .timeout_o     (timeout_o),
    .se            (sif)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // Engine model state and observation logs filled by step().
  int          eng_delay;
  int          eng_timer;
  logic [47:0] iss_mac [$];
  logic        iss_src [$];
  int          ack_order [$];
  int          ack_cnt [4];
  int          nak_total;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    iss_mac.delete();
    iss_src.delete();
    ack_order.delete();
    for (int n = 0; n < 4; n++) ack_cnt[n] = 0;
    nak_total = 0;
    eng_timer = 0;
  endtask

  // One cycle with a reactive engine that acks eng_delay cycles after se_req.
  task automatic step();
    tick();
    if (sif.se_req === 1'b1) begin
      iss_mac.push_back(sif.se_mac);
      iss_src.push_back(sif.se_source);
    end
    for (int n = 0; n < 4; n++) begin
      if (req_ack_o[n] === 1'b1) begin
        ack_cnt[n]++;
        ack_order.push_back(n);
      end
      if (req_nak_o[n] === 1'b1) nak_total++;
    end
    sif.se_ack = 1'b0;
    if (eng_timer > 0) begin
      eng_timer--;
      if (eng_timer == 0) begin
        sif.se_ack    = 1'b1;
        sif.se_result = {12'hC00, sif.se_mac[3:0]};
      end
    end
    if (sif.se_req === 1'b1 && eng_delay > 0) eng_timer = eng_delay;
  endtask

  task automatic set_req(input int n, input logic [47:0] mac, input logic [9:0] hash,
                         input logic src, input logic [15:0] pm);
    req_mac_i[48*n +: 48]     = mac;
    req_hash_i[10*n +: 10]    = hash;
    req_source_i[n]           = src;
    req_portmap_i[16*n +: 16] = pm;
  endtask

  task automatic wait_issue(output int w);
    w = -1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (sif.se_req === 1'b1) begin
        w = k;
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    req_i      = '0;
    sif.se_ack = 1'b0;
    sif.se_nak = 1'b0;
    eng_delay  = 0;
    clear_logs();
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    tests_run++;
    if ({req_ack_o, req_nak_o, req_ovf_o, timeout_o} !== 13'h0) begin
      tests_failed++;
      $display("[TB] FAIL reset_pulses: got %h expected 0", {req_ack_o, req_nak_o, req_ovf_o, timeout_o});
    end
    tests_run++;
    if (req_result_o !== 64'h0) begin
      tests_failed++;
      $display("[TB] FAIL reset_result: got %h expected 0", req_result_o);
    end
    tests_run++;
    if ({sif.se_req, sif.se_mac, sif.se_hash, sif.se_source, sif.source_portmap} !== 76'h0) begin
      tests_failed++;
      $display("[TB] FAIL reset_se_bus: got %h expected 0",
               {sif.se_req, sif.se_mac, sif.se_hash, sif.se_source, sif.source_portmap});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    do_reset();
    set_req(0, 48'h001122334455, 10'h155, 1'b0, 16'h0003);
    req_i = 4'b0001;
    tick();
    req_i = 4'b0000;
    tests_run++;
    if (sif.se_req !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL single_early_req: got %b expected 0", sif.se_req);
    end
    tick();
    tests_run++;
    if (sif.se_req !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL single_req_latency: got %b expected 1", sif.se_req);
    end
    tests_run++;
    if ({sif.se_mac, sif.se_hash, sif.se_source, sif.source_portmap} !==
        {48'h001122334455, 10'h155, 1'b0, 16'h0003}) begin
      tests_failed++;
      $display("[TB] FAIL single_fields: got %h %h %b %h expected 001122334455 155 0 0003",
               sif.se_mac, sif.se_hash, sif.se_source, sif.source_portmap);
    end
    tick();
    tests_run++;
    if (sif.se_req !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL single_req_pulse: got %b expected 0", sif.se_req);
    end
    tick();
    sif.se_ack    = 1'b1;
    sif.se_result = 16'h0004;
    tick();
    sif.se_ack = 1'b0;
    tests_run++;
    if (req_ack_o !== 4'b0001 || req_nak_o !== 4'b0000) begin
      tests_failed++;
      $display("[TB] FAIL single_ack: got ack %b nak %b expected ack 0001 nak 0000", req_ack_o, req_nak_o);
    end
    tests_run++;
    if (req_result_o[15:0] !== 16'h0004) begin
      tests_failed++;
      $display("[TB] FAIL single_result: got %h expected 0004", req_result_o[15:0]);
    end
    tick();
    tests_run++;
    if (req_ack_o !== 4'b0000 || sif.se_mac !== 48'h001122334455) begin
      tests_failed++;
      $display("[TB] FAIL single_ack_pulse: got ack %b mac %h expected 0000 001122334455", req_ack_o, sif.se_mac);
    end
  endtask

  task automatic test_contention();
    logic [47:0] got_mac;
    int          got_idx;
    int          exp2 [2];
    do_reset();
    eng_delay = 1;
    for (int n = 0; n < 4; n++) set_req(n, 48'hA0A000000000 | 48'(n), 10'(n), 1'b0, 16'(n));
    req_i = 4'b1111;
    step();
    req_i = 4'b0000;
    repeat (30) step();
    tests_run++;
    if (iss_mac.size() != 4 || ack_order.size() != 4) begin
      tests_failed++;
      $display("[TB] FAIL rr_count: got %0d issues %0d acks expected 4 4", iss_mac.size(), ack_order.size());
    end
    for (int k = 0; k < 4; k++) begin
      got_mac = (k < iss_mac.size()) ? iss_mac[k] : 48'hx;
      got_idx = (k < ack_order.size()) ? ack_order[k] : -1;
      tests_run++;
      if (got_mac !== (48'hA0A000000000 | 48'(k)) || got_idx != k) begin
        tests_failed++;
        $display("[TB] FAIL rr_order_%0d: got mac %h ack %0d expected mac %h ack %0d",
                 k, got_mac, got_idx, 48'hA0A000000000 | 48'(k), k);
      end
      tests_run++;
      if (req_result_o[16*k +: 16] !== (16'hC000 | 16'(k))) begin
        tests_failed++;
        $display("[TB] FAIL rr_result_%0d: got %h expected %h", k, req_result_o[16*k +: 16], 16'hC000 | 16'(k));
      end
    end
    clear_logs();
    exp2[0] = 0;
    exp2[1] = 2;
    set_req(0, 48'hB0B000000000, 10'h0, 1'b0, 16'h0);
    set_req(2, 48'hB0B000000002, 10'h2, 1'b0, 16'h2);
    req_i = 4'b0101;
    step();
    req_i = 4'b0000;
    repeat (20) step();
    for (int k = 0; k < 2; k++) begin
      got_mac = (k < iss_mac.size()) ? iss_mac[k] : 48'hx;
      got_idx = (k < ack_order.size()) ? ack_order[k] : -1;
      tests_run++;
      if (got_mac !== (48'hB0B000000000 | 48'(exp2[k])) || got_idx != exp2[k]) begin
        tests_failed++;
        $display("[TB] FAIL rr_pair_%0d: got mac %h ack %0d expected requester %0d", k, got_mac, got_idx, exp2[k]);
      end
    end
    tests_run++;
    if (iss_mac.size() != 2 || nak_total != 0) begin
      tests_failed++;
      $display("[TB] FAIL rr_pair_count: got %0d issues %0d naks expected 2 0", iss_mac.size(), nak_total);
    end
  endtask

  task automatic test_frame_pattern();
    logic [47:0] r2_mac [$];
    logic        r2_src [$];
    logic        rereq;
    do_reset();
    eng_delay = 1;
    rereq     = 1'b0;
    set_req(1, 48'h111100000001, 10'h011, 1'b0, 16'h0010);
    for (int c = 0; c < 40; c++) begin
      req_i = 4'b0000;
      if (c == 0) begin
        set_req(2, 48'h2222000000D2, 10'h0D2, 1'b0, 16'h0000);
        req_i[2] = 1'b1;
        req_i[1] = 1'b1;
      end
      if (c == 6) begin
        set_req(2, 48'h2222000000E2, 10'h0E2, 1'b1, 16'h0020);
        req_i[2] = 1'b1;
      end
      if (rereq && c < 25) req_i[1] = 1'b1;
      step();
      rereq = req_ack_o[1];
    end
    req_i = 4'b0000;
    repeat (10) step();
    for (int k = 0; k < iss_mac.size(); k++) begin
      if (iss_mac[k][47:32] == 16'h2222) begin
        r2_mac.push_back(iss_mac[k]);
        r2_src.push_back(iss_src[k]);
      end
    end
    tests_run++;
    if (r2_mac.size() != 2 || ack_cnt[2] != 2) begin
      tests_failed++;
      $display("[TB] FAIL frame_r2_count: got %0d issues %0d acks expected 2 2", r2_mac.size(), ack_cnt[2]);
    end
    tests_run++;
    if (r2_mac.size() != 2 || r2_mac[0] !== 48'h2222000000D2 || r2_src[0] !== 1'b0 ||
        r2_mac[1] !== 48'h2222000000E2 || r2_src[1] !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL frame_r2_order: got %0d entries expected dst 2222000000D2 then src 2222000000E2", r2_mac.size());
    end
    tests_run++;
    if (req_ovf_o !== 4'b0000 || nak_total != 0 || ack_cnt[1] < 3) begin
      tests_failed++;
      $display("[TB] FAIL frame_clean: got ovf %b naks %0d r1 acks %0d expected 0000 0 >=3",
               req_ovf_o, nak_total, ack_cnt[1]);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    eng_delay = 4;
    for (int c = 0; c < 3; c++) begin
      set_req(3, 48'h333300000A00 | 48'(c), 10'(c), 1'b0, 16'(c));
      req_i = 4'b1000;
      step();
    end
    req_i = 4'b0000;
    tests_run++;
    if (req_ovf_o !== 4'b1000) begin
      tests_failed++;
      $display("[TB] FAIL ovf_set: got %b expected 1000", req_ovf_o);
    end
    repeat (40) step();
    tests_run++;
    if (iss_mac.size() != 2 || ack_cnt[3] != 2) begin
      tests_failed++;
      $display("[TB] FAIL ovf_issue_count: got %0d issues %0d acks expected 2 2", iss_mac.size(), ack_cnt[3]);
    end
    tests_run++;
    if (iss_mac.size() != 2 || iss_mac[0] !== 48'h333300000A00 || iss_mac[1] !== 48'h333300000A01) begin
      tests_failed++;
      $display("[TB] FAIL ovf_kept_entries: got %0d issues expected macs 333300000A00 333300000A01", iss_mac.size());
    end
    tests_run++;
    if (req_ovf_o !== 4'b1000) begin
      tests_failed++;
      $display("[TB] FAIL ovf_sticky: got %b expected 1000", req_ovf_o);
    end
  endtask

  task automatic test_nak_timeout();
    int w;
    int k;
    do_reset();
    sif.se_ack    = 1'b1;
    sif.se_result = 16'hDEAD;
    repeat (2) tick();
    sif.se_ack = 1'b0;
    tests_run++;
    if (req_ack_o !== 4'b0000 || req_result_o !== 64'h0) begin
      tests_failed++;
      $display("[TB] FAIL idle_ack_ignored: got ack %b result %h expected 0000 0", req_ack_o, req_result_o);
    end
    set_req(0, 48'h444400000000, 10'h044, 1'b0, 16'h0001);
    req_i = 4'b0001;
    tick();
    req_i = 4'b0000;
    wait_issue(w);
    tests_run++;
    if (w != 1) begin
      tests_failed++;
      $display("[TB] FAIL issue_latency: got %0d expected 1", w);
    end
    tick();
    sif.se_ack    = 1'b1;
    sif.se_result = 16'h1234;
    tick();
    sif.se_ack = 1'b0;
    tests_run++;
    if (req_ack_o !== 4'b0001 || req_result_o[15:0] !== 16'h1234) begin
      tests_failed++;
      $display("[TB] FAIL pre_nak_ack: got ack %b result %h expected 0001 1234", req_ack_o, req_result_o[15:0]);
    end

    req_i = 4'b0001;
    tick();
    req_i = 4'b0000;
    wait_issue(w);
    tick();
    sif.se_nak    = 1'b1;
    sif.se_result = 16'hFFFF;
    tick();
    sif.se_nak = 1'b0;
    tests_run++;
    if (req_nak_o !== 4'b0001 || req_ack_o !== 4'b0000 || timeout_o !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL nak_pulse: got nak %b ack %b tmo %b expected 0001 0000 0", req_nak_o, req_ack_o, timeout_o);
    end
    tests_run++;
    if (req_result_o[15:0] !== 16'h1234) begin
      tests_failed++;
      $display("[TB] FAIL nak_result_kept: got %h expected 1234", req_result_o[15:0]);
    end

    req_i = 4'b0001;
    tick();
    req_i = 4'b0000;
    wait_issue(w);
    for (k = 1; k <= 100; k++) begin
      tick();
      if (req_nak_o !== 4'b0000) break;
    end
    tests_run++;
    if (k != 65 || req_nak_o !== 4'b0001 || timeout_o !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL timeout_nak: got after %0d cycles nak %b tmo %b expected 65 0001 1", k, req_nak_o, timeout_o);
    end
    tick();
    tests_run++;
    if (timeout_o !== 1'b0 || req_nak_o !== 4'b0000) begin
      tests_failed++;
      $display("[TB] FAIL timeout_pulse: got tmo %b nak %b expected 0 0000", timeout_o, req_nak_o);
    end

    req_i = 4'b0001;
    tick();
    req_i = 4'b0000;
    wait_issue(w);
    tick();
    sif.se_ack    = 1'b1;
    sif.se_nak    = 1'b1;
    sif.se_result = 16'h0BEE;
    tick();
    sif.se_ack = 1'b0;
    sif.se_nak = 1'b0;
    tests_run++;
    if (req_ack_o !== 4'b0001 || req_nak_o !== 4'b0000 || req_result_o[15:0] !== 16'h0BEE) begin
      tests_failed++;
      $display("[TB] FAIL collision: got ack %b nak %b result %h expected 0001 0000 0BEE",
               req_ack_o, req_nak_o, req_result_o[15:0]);
    end
  endtask

  task automatic test_reset_mid_wait();
    int w;
    int seen;
    do_reset();
    set_req(2, 48'h555500000002, 10'h2AA, 1'b0, 16'h0F0F);
    req_i = 4'b0100;
    tick();
    req_i = 4'b0000;
    wait_issue(w);
    tick();
    sif.se_ack    = 1'b1;
    sif.se_result = 16'h00AA;
    tick();
    sif.se_ack = 1'b0;
    tests_run++;
    if (req_result_o[47:32] !== 16'h00AA) begin
      tests_failed++;
      $display("[TB] FAIL pre_reset_result: got %h expected 00AA", req_result_o[47:32]);
    end
    set_req(1, 48'h555500000001, 10'h111, 1'b0, 16'h0101);
    req_i = 4'b0110;
    tick();
    req_i = 4'b0000;
    wait_issue(w);
    tests_run++;
    if (w != 1) begin
      tests_failed++;
      $display("[TB] FAIL pre_reset_issue: got %0d expected 1", w);
    end
    tick();
    #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if ({sif.se_req, sif.se_mac, sif.se_hash, sif.se_source, sif.source_portmap} !== 76'h0) begin
      tests_failed++;
      $display("[TB] FAIL async_reset_bus: got %h expected 0",
               {sif.se_req, sif.se_mac, sif.se_hash, sif.se_source, sif.source_portmap});
    end
    tests_run++;
    if ({req_ack_o, req_nak_o, req_ovf_o, timeout_o} !== 13'h0 || req_result_o !== 64'h0) begin
      tests_failed++;
      $display("[TB] FAIL async_reset_outputs: got %h %h expected 0 0",
               {req_ack_o, req_nak_o, req_ovf_o, timeout_o}, req_result_o);
    end
    repeat (2) tick();
    rst  = 1'b0;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (sif.se_req === 1'b1 || req_ack_o !== 4'b0000 || req_nak_o !== 4'b0000) seen++;
    end
    tests_run++;
    if (seen != 0) begin
      tests_failed++;
      $display("[TB] FAIL reset_queues_empty: got %0d active cycles expected 0", seen);
    end
    set_req(0, 48'h666600000000, 10'h000, 1'b0, 16'h0000);
    set_req(2, 48'h666600000002, 10'h002, 1'b0, 16'h0002);
    req_i = 4'b0101;
    tick();
    req_i = 4'b0000;
    wait_issue(w);
    tests_run++;
    if (w != 1 || sif.se_mac !== 48'h666600000000) begin
      tests_failed++;
      $display("[TB] FAIL post_reset_priority: got wait %0d mac %h expected 1 666600000000", w, sif.se_mac);
    end
  endtask

  initial begin
    rst           = 1'b1;
    req_i         = '0;
    req_mac_i     = '0;
    req_hash_i    = '0;
    req_source_i  = '0;
    req_portmap_i = '0;
    sif.se_ack    = 1'b0;
    sif.se_nak    = 1'b0;
    sif.se_result = '0;
    eng_delay     = 0;
    clear_logs();
    test_reset();
    test_single();
    test_contention();
    test_frame_pattern();
    test_overflow();
    test_nak_timeout();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/se_req_arbiter.md
Name: se_req_arbiter

Overview:
- Shares one MAC search engine (se_req/se_ack/se_nak/se_result) between 4 frame processors.
- Each frame processor issues two single-cycle lookup pulses per frame: destination, then source.
- The block buffers requests per requester, grants round-robin, and holds one search outstanding at a time.
- It routes ack/nak/result back to the originating requester, with a timeout guard.

Parameters:
- TIMEOUT, 64: cycles in WAIT without se_ack/se_nak before the block aborts the search.
- QDEPTH, 2: per-requester request buffer depth. Fixed at 2 (one dst plus one src lookup per frame).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- req_i  in  4  per-requester lookup pulse, one cycle each
- req_mac_i  in  192  requester n MAC at [48n+:48]
- req_hash_i  in  40  requester n hash at [10n+:10]
- req_source_i  in  4  0 = destination lookup, 1 = source learn
- req_portmap_i  in  64  requester n source portmap at [16n+:16]
- req_ack_o  out  4  per-requester ack pulse, one cycle
- req_nak_o  out  4  per-requester nak pulse, one cycle
- req_result_o  out  64  requester n last result at [16n+:16], held until next ack
- req_ovf_o  out  4  sticky: request dropped because the requester's queue was full
- se_mac  out  48  to search engine
- se_hash  out  10  to search engine
- se_source  out  1  to search engine
- source_portmap  out  16  to search engine
- se_req  out  1  search request pulse, one cycle
- se_ack  in  1  search hit/done
- se_nak  in  1  search fail
- se_result  in  16  result portmap, valid with se_ack
- timeout_o  out  1  one-cycle pulse when a search times out

Behaviour:
- Reset (async, rst=1) clears all of these to 0: queues empty, FSM=IDLE, every output, timeout counter. last_grant resets to 3, so requester 0 has first priority.
- Queues: 2-entry FIFO per requester, entry = {source, portmap, hash, mac}.
  - req_i[n] pushes on that clk edge.
  - Push when full: request dropped, req_ovf_o[n] <= 1 (cleared only by reset).
  - Push and pop on the same edge with the queue full: accepted, no overflow.
- FSM IDLE:
  - If any queue is non-empty, grant g = first non-empty requester scanning last_grant+1, +2, … mod 4.
  - Register the head entry of g onto se_mac, se_hash, se_source, source_portmap; go to ISSUE.
- FSM ISSUE: se_req=1 for exactly this cycle; go to WAIT; clear the timeout counter.
- se_* fields stay stable from ISSUE until the next grant.
- FSM WAIT (counter increments every cycle). First matching condition wins:
  - se_ack: req_result_o[g] <= se_result; req_ack_o[g] pulses next cycle; pop queue g; last_grant <= g; go to IDLE.
  - se_nak: req_nak_o[g] pulses; result unchanged; pop; last_grant <= g; go to IDLE.
  - counter == TIMEOUT-1 with neither: same as nak, plus timeout_o pulses.
- se_ack and se_nak in the same cycle: ack wins. se_ack/se_nak outside WAIT are ignored.
- Latency, idle block:
  - req_i at edge t → se_req high in cycle t+2.
  - se_ack sampled at edge w → req_ack_o high in cycle w+1; earliest next se_req in cycle w+2.
- Ordering: a requester's requests are served in arrival order (dst before src). Between requesters, strict round-robin, no starvation.
- Reset asserted mid-search: outstanding search abandoned, no ack/nak emitted. The search engine must tolerate a dropped request.

Test Plan:
- Single request: req_i=0001, mac=0x001122334455, hash=0x155, source=0 → se_req pulse 2 cycles later with those fields. Engine acks 3 cycles later with result 0x0004 → req_ack_o=0001 for one cycle, req_result_o[15:0]=0x0004.
- Contention: req_i=1111 in one cycle, engine acks each request after 1 cycle → grants in order 0,1,2,3. Then req_i=0101 → order 0,2 (last_grant=3). No ack is delivered to the wrong requester.
- Frame pattern: requester 2 pulses dst, then src 6 cycles later, while requester 1 busy-loops → requester 2 gets both acks, dst first; no overflow.
- Overflow: 3 pulses on requester 3 with the engine stalled → req_ovf_o=1000 sticky. Exactly 2 searches issued for requester 3.
- Nak/timeout/collision:
  - se_nak → req_nak_o pulse, result unchanged.
  - No response → after 64 WAIT cycles, nak and timeout_o pulse.
  - se_ack and se_nak asserted together → ack only.
- Reset mid-WAIT: rst pulse → all outputs 0 immediately (async), queues empty. The next request is served by requester 0 first.
